sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: extra idle cycles after the second half-word access, for SRAM settling (range 0..15).
REQ-002 Parameter DATA_MEM_BASE, default 1024: byte address that maps to SRAM word 0.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  store request from the EXE/MEM pipeline register.
REQ-006 rd_en  input  1  load request from the EXE/MEM pipeline register.
REQ-007 address  input  32  byte address (ALU result).
REQ-008 write_data  input  32  store data (Rm value).
REQ-009 read_data  output  32  loaded word, registered.
REQ-010 ready  output  1  high when the pipeline may advance; low freezes all stages.
REQ-011 SRAM_ADDR  output  18  half-word address to external SRAM.
REQ-012 SRAM_WE_N  output  1  SRAM write strobe, active-low.
REQ-013 SRAM_DQ_out  output  16  write data to SRAM.
REQ-014 SRAM_DQ_oe  output  1  drive enable for SRAM_DQ_out.
REQ-015 SRAM_DQ_in  input  16  read data from SRAM.

Function
REQ-016 The FSM states SHALL be IDLE, LOW, HIGH, WAIT and DONE.
REQ-017 IDLE: when wr_en or rd_en is sampled high, go to LOW and latch the operation type, address and write_data; otherwise stay in IDLE.
REQ-018 If wr_en and rd_en are both high, write SHALL take priority.
REQ-019 Word index = (address - DATA_MEM_BASE) >> 2, modulo 2^17; SRAM_ADDR = {index[16:0], 0} in LOW and {index[16:0], 1} in HIGH.
REQ-020 LOW: a write drives SRAM_DQ_out = data[15:0], SRAM_DQ_oe = 1, SRAM_WE_N = 0; a read captures SRAM_DQ_in into read_data[15:0] at the end of the cycle; go to HIGH.
REQ-021 HIGH: same as LOW but with data[31:16] and read_data[31:16]; go to WAIT, or to DONE if WAIT_CYCLES = 0.
REQ-022 WAIT: a 4-bit counter runs for WAIT_CYCLES cycles, then goes to DONE; SRAM_WE_N = 1 and SRAM_DQ_oe = 0.
REQ-023 DONE: go to IDLE unconditionally; this state lasts exactly one cycle.
REQ-024 ready = NOT((wr_en OR rd_en) AND state != DONE), computed combinationally.
REQ-025 Latency: if a request is first seen in cycle 0, ready SHALL be high in cycle 3 + WAIT_CYCLES and never earlier.
REQ-026 Deasserting the request mid-operation (for example on a flush) SHALL NOT abort the access; the FSM completes through DONE.
REQ-027 Outside LOW and HIGH writes: SRAM_WE_N = 1 and SRAM_DQ_oe = 0.
REQ-028 read_data SHALL hold its value until the next read's LOW/HIGH captures; writes SHALL NOT alter it.
REQ-029 In IDLE, SRAM_ADDR SHALL equal 0.

Reset
REQ-030 While rst = 0, regardless of clk:
  - state = IDLE, wait counter = 0;
  - read_data = 0, SRAM_ADDR = 0, SRAM_DQ_out = 0;
  - SRAM_WE_N = 1, SRAM_DQ_oe = 0.
REQ-031 Reset asserted mid-operation SHALL abandon the access immediately; no further SRAM strobes occur after rst is released until a new request is seen.

Structure
REQ-032 The state enum, DATA_MEM_BASE default and SRAM width constants (16 data bits, 18 address bits) SHALL live in the shared package.
REQ-033 The block is a single module with no sub-modules; the wait counter is inline.
REQ-034 ready SHALL be combined into the freeze inputs of all pipeline registers at the top level.

Verification
REQ-035 Store 0xDEADBEEF to address 1024 with WAIT_CYCLES = 2 -> SRAM_ADDR 0 with DQ 0xBEEF and WE_N low, then SRAM_ADDR 1 with DQ 0xDEAD; ready low for cycles 0-4, high in cycle 5.
REQ-036 Load from address 1032 with the model returning 0x1234 then 0xABCD -> SRAM_ADDR 4 then 5, read_data = 0xABCD1234 in DONE; SRAM_DQ_oe stays 0 throughout.
REQ-037 wr_en and rd_en both high at address 1028 -> a write to SRAM_ADDR 2/3 is performed.
REQ-038 rst pulled low in the HIGH state of a store -> SRAM_WE_N = 1 and SRAM_DQ_oe = 0 immediately; after release, state is IDLE, ready = 1 and no strobe occurs.
REQ-039 Request dropped in the LOW state -> the HIGH write still occurs and DONE is reached; WAIT_CYCLES = 0 -> ready high in cycle 3.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the two-half-word SRAM access controller.
// Holds the FSM state encoding, SRAM geometry and the byte-address to word-index mapping.
package sram_controller_pkg;

  localparam int SRAM_DW               = 16;
  localparam int SRAM_AW               = 18;
  localparam int IDX_W                 = SRAM_AW - 1;
  localparam int DATA_MEM_BASE_DEFAULT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Word index relative to the data-memory base, wrapped to the SRAM word space.
  function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr,
                                                  input logic [31:0] base);
    return IDX_W'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side request/response bus plus the external SRAM pins of the controller.
// The controller uses the slave modport; the pipeline/SRAM side uses master.
interface sram_controller_if;
  import sram_controller_pkg::*;

  logic               wr_en;
  logic               rd_en;
  logic [31:0]        address;
  logic [31:0]        write_data;
  logic [31:0]        read_data;
  logic               ready;
  logic [SRAM_AW-1:0] SRAM_ADDR;
  logic               SRAM_WE_N;
  logic [SRAM_DW-1:0] SRAM_DQ_out;
  logic               SRAM_DQ_oe;
  logic [SRAM_DW-1:0] SRAM_DQ_in;

  modport master (
    output wr_en, rd_en, address, write_data, SRAM_DQ_in,
    input  read_data, ready, SRAM_ADDR, SRAM_WE_N, SRAM_DQ_out, SRAM_DQ_oe
  );

  modport slave (
    input  wr_en, rd_en, address, write_data, SRAM_DQ_in,
    output read_data, ready, SRAM_ADDR, SRAM_WE_N, SRAM_DQ_out, SRAM_DQ_oe
  );

endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit load/store into two 16-bit SRAM accesses (low then high half),
// followed by an optional settling wait; ready stalls the pipeline until DONE.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES   = 2,
  parameter int DATA_MEM_BASE = DATA_MEM_BASE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  sram_controller_if.slave bus
);

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t             r_state;
  logic [3:0]         r_wait_cnt;
  logic               r_is_write;
  logic [IDX_W-1:0]   r_index;
  logic [15:0]        r_wdata_hi;
  logic [31:0]        r_read_data;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic               r_we_n;
  logic               r_dq_oe;
  logic [15:0]        r_dq_out;

  logic               w_req;
  logic [IDX_W-1:0]   w_index;

  assign w_req   = bus.wr_en | bus.rd_en;
  assign w_index = word_index(bus.address, 32'(DATA_MEM_BASE));

  // SRAM pins are registered, so they are loaded one state ahead of the access they drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= 4'd0;
      r_is_write  <= 1'b0;
      r_index     <= '0;
      r_wdata_hi  <= 16'd0;
      r_read_data <= 32'd0;
      r_sram_addr <= '0;
      r_we_n      <= 1'b1;
      r_dq_oe     <= 1'b0;
      r_dq_out    <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_state     <= ST_LOW;
            r_is_write  <= bus.wr_en;
            r_index     <= w_index;
            r_wdata_hi  <= bus.write_data[31:16];
            r_sram_addr <= {w_index, 1'b0};
            r_we_n      <= ~bus.wr_en;
            r_dq_oe     <= bus.wr_en;
            if (bus.wr_en) r_dq_out <= bus.write_data[15:0];
          end
        end
        ST_LOW: begin
          if (!r_is_write) r_read_data[15:0] <= bus.SRAM_DQ_in;
          else             r_dq_out          <= r_wdata_hi;
          r_sram_addr <= {r_index, 1'b1};
          r_state     <= ST_HIGH;
        end
        ST_HIGH: begin
          if (!r_is_write) r_read_data[31:16] <= bus.SRAM_DQ_in;
          r_sram_addr <= '0;
          r_we_n      <= 1'b1;
          r_dq_oe     <= 1'b0;
          r_wait_cnt  <= 4'd0;
          r_state     <= (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          if (r_wait_cnt == WAIT_LAST) r_state    <= ST_DONE;
          else                         r_wait_cnt <= r_wait_cnt + 4'd1;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A dropped request sees ready high, so a flush never waits on an access in flight.
  assign bus.ready       = ~(w_req & (r_state != ST_DONE));
  assign bus.read_data   = r_read_data;
  assign bus.SRAM_ADDR   = r_sram_addr;
  assign bus.SRAM_WE_N   = r_we_n;
  assign bus.SRAM_DQ_out = r_dq_out;
  assign bus.SRAM_DQ_oe  = r_dq_oe;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized scoreboard bench for sram_controller against a word-level memory model,
// plus directed checks for zero wait cycles, dropped requests and mid-access reset.
module tb_sram_controller;
  import sram_controller_pkg::*;

  localparam int W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_controller_if bus ();
  sram_controller_if bus0 ();

  sram_controller #(.WAIT_CYCLES(W), .DATA_MEM_BASE(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sram_controller #(.WAIT_CYCLES(0), .DATA_MEM_BASE(1024)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pat(input int unsigned a);
    return 16'(a * 32'd40503 + 32'd7);
  endfunction

  function automatic int unsigned idx_of(input logic [31:0] addr);
    int unsigned off;
    off = addr - 32'd1024;
    return (off / 4) % 131072;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // External SRAM model for dut: half-word array, strobe and drive-enable event logs.
  logic [15:0]  sram_mem [0:262143];
  int unsigned  strobes [$];
  bit           oe_q [$];

  always @(posedge clk) begin
    if (bus.SRAM_DQ_oe) oe_q.push_back(1'b1);
    if (!bus.SRAM_WE_N) begin
      sram_mem[bus.SRAM_ADDR] = bus.SRAM_DQ_out;
      strobes.push_back(32'(bus.SRAM_ADDR));
    end
  end

  always @(negedge clk) bus.SRAM_DQ_in = sram_mem[bus.SRAM_ADDR];

  assign bus0.SRAM_DQ_in = pat(32'(bus0.SRAM_ADDR));

  // Word-level reference: what each 32-bit data word should hold.
  logic [31:0] ref_mem [int unsigned];

  function automatic logic [31:0] ref_read(input int unsigned i);
    if (ref_mem.exists(i)) return ref_mem[i];
    return {pat(2 * i + 1), pat(2 * i)};
  endfunction

  typedef struct {
    int unsigned start;
    bit          is_write;
    int unsigned idx;
    logic [31:0] data;
  } txn_t;

  txn_t        sb_q [$];
  bit          sb_en   = 1'b0;
  logic [31:0] last_rd = 32'd0;

  // Monitor: a completion is a held request seeing ready high.
  always @(negedge clk) begin
    txn_t t;
    if (sb_en && (bus.wr_en || bus.rd_en) && bus.ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: got completion expected none (cyc %0d)", cyc);
      end else begin
        t = sb_q.pop_front();
        check("latency", cyc - t.start, 3 + W);
        if (t.is_write) begin
          check("wr_strobe_count", strobes.size(), 2);
          if (strobes.size() == 2) begin
            check("wr_addr_lo", strobes[0], 2 * t.idx);
            check("wr_addr_hi", strobes[1], 2 * t.idx + 1);
          end
          check("wr_sram_lo", 32'(sram_mem[2 * t.idx]), 32'(t.data[15:0]));
          check("wr_sram_hi", 32'(sram_mem[2 * t.idx + 1]), 32'(t.data[31:16]));
          check("wr_oe_cycles", oe_q.size(), 2);
          check("rd_data_hold", bus.read_data, last_rd);
        end else begin
          check("rd_strobe_count", strobes.size(), 0);
          check("rd_oe_cycles", oe_q.size(), 0);
          check("rd_data", bus.read_data, t.data);
          last_rd = t.data;
        end
        $display("txn %s idx=%05h data=%08h lat=%0d", t.is_write ? "WR" : "RD",
                 t.idx, t.data, cyc - t.start);
        strobes.delete();
        oe_q.delete();
      end
    end
  end

  task automatic issue(input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [31:0] data);
    txn_t t;
    bit   done;
    @(negedge clk);
    #1;
    bus.wr_en      = wr;
    bus.rd_en      = rd;
    bus.address    = addr;
    bus.write_data = data;
    t.start    = cyc;
    t.is_write = wr;
    t.idx      = idx_of(addr);
    if (wr) begin
      t.data          = data;
      ref_mem[t.idx]  = data;
    end else begin
      t.data = ref_read(t.idx);
    end
    sb_q.push_back(t);
    done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.ready) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready=0 after 40 cycles expected ready=1");
    end
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  initial begin
    int unsigned s0;
    bit          ok;
    logic [31:0] a;
    int          r;

    rst = 1'b0;
    bus.wr_en = 1'b0;  bus.rd_en = 1'b0;  bus.address = '0;  bus.write_data = '0;
    bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.address = '0; bus0.write_data = '0;
    for (int i = 0; i < 262144; i++) sram_mem[i] = pat(i);

    repeat (3) @(negedge clk);
    check("rst_read_data", bus.read_data, 32'd0);
    check("rst_sram_addr", 32'(bus.SRAM_ADDR), 32'd0);
    check("rst_we_n", 32'(bus.SRAM_WE_N), 32'd1);
    check("rst_oe", 32'(bus.SRAM_DQ_oe), 32'd0);
    check("rst_dq_out", 32'(bus.SRAM_DQ_out), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd1);
    #1 rst = 1'b1;

    // Zero-wait instance: store dropped during LOW must still finish both halves.
    @(negedge clk);
    #1;
    bus0.wr_en = 1'b1; bus0.address = 32'd1028; bus0.write_data = 32'hCAFEF00D;
    @(negedge clk);
    check("w0_low_we_n", 32'(bus0.SRAM_WE_N), 32'd0);
    check("w0_low_addr", 32'(bus0.SRAM_ADDR), 32'd2);
    check("w0_low_dq", 32'(bus0.SRAM_DQ_out), 32'h0000F00D);
    check("w0_low_oe", 32'(bus0.SRAM_DQ_oe), 32'd1);
    #1 bus0.wr_en = 1'b0;
    @(negedge clk);
    check("w0_high_we_n", 32'(bus0.SRAM_WE_N), 32'd0);
    check("w0_high_addr", 32'(bus0.SRAM_ADDR), 32'd3);
    check("w0_high_dq", 32'(bus0.SRAM_DQ_out), 32'h0000CAFE);
    @(negedge clk);
    check("w0_done_we_n", 32'(bus0.SRAM_WE_N), 32'd1);
    check("w0_done_oe", 32'(bus0.SRAM_DQ_oe), 32'd0);
    @(negedge clk);
    check("w0_idle_addr", 32'(bus0.SRAM_ADDR), 32'd0);
    #1;
    bus0.rd_en = 1'b1; bus0.address = 32'd1028;
    s0 = cyc;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus0.ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL w0_ready_timeout: got ready=0 expected ready=1");
    end
    check("w0_latency", cyc - s0, 32'd3);
    check("w0_rd_data", bus0.read_data, {pat(3), pat(2)});
    $display("txn W0-RD idx=00001 data=%08h lat=%0d", bus0.read_data, cyc - s0);
    #1 bus0.rd_en = 1'b0;

    // Scoreboarded traffic on the WAIT_CYCLES=2 instance.
    strobes.delete();
    oe_q.delete();
    sb_en = 1'b1;
    sram_mem[4]  = 16'h1234;
    sram_mem[5]  = 16'hABCD;
    ref_mem[2]   = 32'hABCD1234;
    issue(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    issue(1'b0, 1'b1, 32'd1032, 32'd0);
    issue(1'b1, 1'b1, 32'd1028, $urandom);
    issue(1'b0, 1'b1, 32'd1028, 32'd0);
    @(negedge clk);
    check("idle_addr", 32'(bus.SRAM_ADDR), 32'd0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'd1024 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (r < 4)      issue(1'b1, 1'b0, a, $urandom);
      else if (r < 8) issue(1'b0, 1'b1, a, $urandom);
      else            issue(1'b1, 1'b1, a, $urandom);
    end
    @(negedge clk);
    sb_en = 1'b0;
    check("sb_drained", sb_q.size(), 0);

    // Reset during the HIGH half of a store.
    #1;
    bus.wr_en = 1'b1; bus.address = 32'd1040; bus.write_data = 32'h11112222;
    @(negedge clk);
    @(negedge clk);
    check("mid_high_we_n", 32'(bus.SRAM_WE_N), 32'd0);
    rst = 1'b0;
    bus.wr_en = 1'b0;
    #1;
    check("mid_rst_we_n", 32'(bus.SRAM_WE_N), 32'd1);
    check("mid_rst_oe", 32'(bus.SRAM_DQ_oe), 32'd0);
    check("mid_rst_addr", 32'(bus.SRAM_ADDR), 32'd0);
    check("mid_rst_read_data", bus.read_data, 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    strobes.delete();
    oe_q.delete();
    repeat (5) @(negedge clk);
    check("post_rst_strobes", strobes.size(), 0);
    check("post_rst_oe", oe_q.size(), 0);
    check("post_rst_ready", 32'(bus.ready), 32'd1);
    check("post_rst_addr", 32'(bus.SRAM_ADDR), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
